// File: rtl/dot_pkg.sv
// Shared types and helpers for the streaming dot-product datapath.
// Lane 0 of a packed beat sits in the most significant bits.
package dot_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Result width that holds any N-term sum of DW x DW products.
   function automatic int result_width(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   // Bit offset of lane idx inside a packed beat (lane 0 = MSBs).
   function automatic int lane_lsb(input int lanes, input int dw,
                                   input int idx);
      return (lanes - 1 - idx) * dw;
   endfunction

endpackage

// File: rtl/dot_product_stream_lane_mac.sv
// Combinational per-beat multiply stage: lane products, extended to the
// result width according to the mode, then summed into one beat sum.
module lane_mac
   import dot_pkg::*;
#(
   parameter int DW    = 8,
   parameter int LANES = 2,
   parameter int OW    = 19
) (
   input  logic                  signed_mode_i,
   input  logic [LANES*DW-1:0]   a_i,
   input  logic [LANES*DW-1:0]   b_i,
   output logic [OW-1:0]         sum_o
);

   localparam int PW = 2 * DW + 2;

   logic [DW-1:0]         la;
   logic [DW-1:0]         lb;
   logic [DW:0]           xa;
   logic [DW:0]           xb;
   logic signed [PW-1:0]  ea;
   logic signed [PW-1:0]  eb;
   logic signed [PW-1:0]  pf;
   logic [2*DW-1:0]       p;
   logic [OW-1:0]         pe;

   // Multiply each lane with an extra sign bit, then accumulate the lanes.
   always_comb begin
      sum_o = '0;
      la    = '0;
      lb    = '0;
      xa    = '0;
      xb    = '0;
      ea    = '0;
      eb    = '0;
      pf    = '0;
      p     = '0;
      pe    = '0;
      for (int l = 0; l < LANES; l++) begin
         la = a_i[lane_lsb(LANES, DW, l) +: DW];
         lb = b_i[lane_lsb(LANES, DW, l) +: DW];
         xa = {signed_mode_i & la[DW-1], la};
         xb = {signed_mode_i & lb[DW-1], lb};
         ea = PW'($signed(xa));
         eb = PW'($signed(xb));
         pf = ea * eb;
         p  = pf[2*DW-1:0];
         if (signed_mode_i) begin
            pe = OW'($signed(p));
         end else begin
            pe = OW'(p);
         end
         sum_o = sum_o + pe;
      end
   end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot product: accepts LANES element pairs per beat, accumulates
// BEATS beats, then holds the result on a valid/ready output.
module dot_product_stream
   import dot_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int DW    = 8,
   parameter  int LANES = 2,
   localparam int OW    = result_width(N, DW)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  signed_mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   inp1,
   input  logic [LANES*DW-1:0]   inp2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OW-1:0]         outp,
   output logic                  busy
);

   localparam int BEATS = N / LANES;
   localparam int CW    = $clog2(BEATS + 1);

   if (LANES < 1 || (N % LANES) != 0) begin : g_bad_params
      $error("dot_product_stream: N must be a positive multiple of LANES");
   end

   state_e          state_q, state_d;
   logic [OW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic            accept;
   logic            mac_mode;
   logic [OW-1:0]   beat_sum;

   // The first beat uses the live mode pin; later beats use the latched one.
   assign mac_mode  = (state_q == IDLE) ? signed_mode : mode_q;
   assign in_ready  = rst_n && (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign outp      = out_valid ? acc_q : '0;
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid && in_ready;

   lane_mac #(
      .DW    (DW),
      .LANES (LANES),
      .OW    (OW)
   ) u_mac (
      .signed_mode_i (mac_mode),
      .a_i           (inp1),
      .b_i           (inp2),
      .sum_o         (beat_sum)
   );

   // Next-state, accumulate and handshake decisions; clear overrides all.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d  = signed_mode;
               acc_d   = beat_sum;
               cnt_d   = CW'(1);
               state_d = (BEATS == 1) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d = acc_q + beat_sum;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(BEATS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end
   end

   // State, accumulator, beat counter and latched mode registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed plus randomized bench for dot_product_stream (N=8, DW=8,
// LANES=2) against an element-wise integer reference model.
module tb_dot_product_stream;

   localparam int N     = 8;
   localparam int DW    = 8;
   localparam int LANES = 2;
   localparam int OW    = 19;
   localparam int BEATS = N / LANES;

   logic                 clk;
   logic                 rst_n;
   logic                 clear;
   logic                 signed_mode;
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*DW-1:0]  inp1;
   logic [LANES*DW-1:0]  inp2;
   logic                 out_valid;
   logic                 out_ready;
   logic [OW-1:0]        outp;
   logic                 busy;

   int checks;
   int errors;

   logic [DW-1:0] va [N];
   logic [DW-1:0] vb [N];

   dot_product_stream #(
      .N     (N),
      .DW    (DW),
      .LANES (LANES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .inp1        (inp1),
      .inp2        (inp2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .outp        (outp),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, obs, obs, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer dot product, reduced to OW bits.
   function automatic logic [OW-1:0] model(input bit smode);
      int          s;
      logic [31:0] sv;
      s = 0;
      for (int i = 0; i < N; i++) begin
         if (smode) s += int'($signed(va[i])) * int'($signed(vb[i]));
         else       s += int'(va[i]) * int'(vb[i]);
      end
      sv = s;
      return sv[OW-1:0];
   endfunction

   task automatic fill(input int a, input int b);
      for (int i = 0; i < N; i++) begin
         va[i] = a[DW-1:0];
         vb[i] = b[DW-1:0];
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N; i++) begin
         va[i] = DW'($urandom);
         vb[i] = DW'($urandom);
      end
   endtask

   task automatic drive_beat(input int b, input bit smode);
      in_valid    = 1'b1;
      inp1        = {va[2*b], va[2*b+1]};
      inp2        = {vb[2*b], vb[2*b+1]};
      signed_mode = smode;
   endtask

   task automatic idle_inputs();
      in_valid    = 1'b0;
      inp1        = LANES*DW'($urandom);
      inp2        = LANES*DW'($urandom);
      signed_mode = 1'($urandom);
   endtask

   // Push the first nb beats of the current vectors, no bubbles.
   task automatic feed(input int nb, input bit smode);
      for (int b = 0; b < nb; b++) begin
         drive_beat(b, smode);
         step();
      end
      idle_inputs();
   endtask

   task automatic run_vec(input bit smode, input bit toggle,
                          input int maxbub, input int hold,
                          input string tag);
      logic [OW-1:0] exp;
      int            nb;
      exp = model(smode);
      for (int b = 0; b < BEATS; b++) begin
         nb = (maxbub > 0) ? int'($urandom_range(0, maxbub)) : 0;
         for (int k = 0; k < nb; k++) begin
            idle_inputs();
            step();
         end
         drive_beat(b, (b == 0) ? smode : (toggle ? ~smode : smode));
         check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
         if (b == BEATS - 1) begin
            check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
         end
         step();
      end
      idle_inputs();
      out_ready = (hold == 0);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".outp"}, 32'(outp), 32'(exp));
      check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         step();
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_outp"}, 32'(outp), 32'(exp));
         check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      check({tag, ".released"}, 32'(out_valid), 32'd0);
      check({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      clear       = 1'b0;
      out_ready   = 1'b1;
      idle_inputs();
      #23;
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.outp", 32'(outp), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst.in_ready", 32'(in_ready), 32'd1);
      check("post_rst.busy", 32'(busy), 32'd0);

      // Small unsigned vector: 2*2 + 4*4 = 20.
      fill(0, 0);
      va[0] = 8'd2; va[1] = 8'd4;
      vb[0] = 8'd2; vb[1] = 8'd4;
      check("unsigned.model", 32'(model(1'b0)), 32'd20);
      run_vec(1'b0, 1'b0, 0, 0, "unsigned");

      // All-ones-byte unsigned: 8 * 255 * 255 with no wrap.
      fill(255, 255);
      run_vec(1'b0, 1'b0, 0, 0, "umax");
      check("umax.model", 32'(model(1'b0)), 32'd520200);

      // Signed extreme with mode toggled after beat 0.
      fill(128, 127);
      run_vec(1'b1, 1'b1, 0, 0, "signed");
      check("signed.model", 32'(model(1'b1)), 32'(19'h60400));

      // Bubbles between beats and 5 cycles of output backpressure.
      fill_rand();
      run_vec(1'b0, 1'b0, 3, 5, "backpressure");

      // clear with a simultaneous beat drops that beat and returns to IDLE.
      fill_rand();
      feed(2, 1'b0);
      check("clear.busy_before", 32'(busy), 32'd1);
      drive_beat(2, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      idle_inputs();
      check("clear.busy", 32'(busy), 32'd0);
      check("clear.in_ready", 32'(in_ready), 32'd1);
      check("clear.out_valid", 32'(out_valid), 32'd0);
      fill(1, 1);
      run_vec(1'b0, 1'b0, 0, 0, "after_clear");

      // clear while holding a result in DONE.
      fill_rand();
      feed(BEATS, 1'b1);
      out_ready = 1'b0;
      check("clear_done.valid", 32'(out_valid), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      out_ready = 1'b1;
      check("clear_done.dropped", 32'(out_valid), 32'd0);
      check("clear_done.busy", 32'(busy), 32'd0);

      // Async reset between edges in the middle of ACCUM.
      fill_rand();
      feed(2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset.busy", 32'(busy), 32'd0);
      check("areset.out_valid", 32'(out_valid), 32'd0);
      check("areset.outp", 32'(outp), 32'd0);
      check("areset.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      fill_rand();
      run_vec(1'b1, 1'b0, 0, 0, "after_areset");

      // Async reset while a result is held in DONE.
      fill_rand();
      feed(BEATS, 1'b0);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_done.out_valid", 32'(out_valid), 32'd0);
      check("areset_done.outp", 32'(outp), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      // Randomized vectors, modes, bubbles and backpressure.
      for (int t = 0; t < 30; t++) begin
         fill_rand();
         run_vec(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
- Sequential, parametrised successor to the combinational dot_product.
- Accepts two N-element vectors streamed LANES elements per beat over a valid/ready handshake.
- Multiplies lane-wise and accumulates, then presents the full dot product on a valid/ready output.
- Adds signed/unsigned mode and a synchronous abort; sits between the operand buffers and the result consumer in the inner-product datapath.

Parameters:
- N, 8, total elements per vector; must be a multiple of LANES.
- DW, 8, element width in bits.
- LANES, 2, elements consumed per input beat.
- OW (localparam), 2*DW + $clog2(N), result width.
- BEATS (localparam), N/LANES, input beats per vector.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous abort: discard the partial sum and return to IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the first beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- inp1  in  LANES*DW  lanes of vector A; lane 0 in the MSBs (element order matches dot_product).
- inp2  in  LANES*DW  lanes of vector B, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- outp  out  OW  dot product; two's complement if the latched mode is signed, else unsigned.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, accumulator=0, beat counter=0, latched mode=0.
  - in_ready=0 while rst_n is low; outputs out_valid=0, outp=0, busy=0.
  - Release takes effect on the next clk edge.
- Accept: in_valid && in_ready on a rising edge.
- FSM IDLE:
  - in_ready=1.
  - On accept: latch signed_mode, acc <= sum of lane products, cnt <= 1, go to ACCUM.
  - If BEATS==1, go directly to DONE.
- FSM ACCUM:
  - in_ready=1.
  - On accept: acc <= acc + sum of lane products, cnt++.
  - On the accept with cnt==BEATS-1, go to DONE.
  - No accept means hold; bubbles are allowed.
- FSM DONE:
  - in_ready=0, out_valid=1, outp=acc; both held stable until out_ready.
  - On out_valid && out_ready: go to IDLE, clear acc and cnt.
- Latency: out_valid rises the cycle after the last beat is accepted.
  - Minimum issue interval is BEATS+1 cycles per vector pair when out_ready is held 1.
- Arithmetic:
  - Products are 2*DW wide, sign- or zero-extended to OW before summation.
  - OW guarantees no overflow for any operands in either mode; no saturation logic.
- Mode: the value latched on the first beat governs the whole vector; signed_mode changes mid-vector are ignored.
- clear:
  - From any state, next state is IDLE with acc=0, cnt=0, out_valid=0.
  - Has priority over a simultaneous input accept or output handshake; the beat is dropped.
- Data capture: inp1/inp2 are don't-care when not accepted; they are not registered beyond the accumulate.
- Parameter check: an elaboration-time $error if N % LANES != 0 or LANES < 1.

Decomposition:
- Shared package dot_pkg:
  - state enum {IDLE, ACCUM, DONE};
  - function result_width(N, DW);
  - the lane-extraction helper (lane 0 = MSB).
- Sub-module lane_mac, combinational: LANES multipliers with a mode-aware sign/zero-extend and an adder tree producing an OW-wide beat sum.
- The top level holds the FSM, beat counter and accumulator.

Test Plan (N=8, DW=8, LANES=2, OW=19):
- Unsigned: A=B={2,4,0,0,0,0,0,0} over 4 beats with out_ready=1 -> out_valid exactly one cycle after the 4th accept, outp=20, then back to IDLE.
- Unsigned max: all elements 255 in both vectors -> outp=520200; no wrap.
- Signed: A all -128, B all 127, signed_mode=1 on beat 0 then toggled to 0 -> outp=-130048 (19-bit two's complement), mode held.
- Backpressure and bubbles:
  - in_valid gaps between beats, out_ready held 0 for 5 cycles -> outp/out_valid stable, in_ready=0 throughout DONE.
  - Result is released on the first out_ready cycle.
- clear:
  - Asserted after 2 beats together with in_valid -> IDLE, beat dropped.
  - A following full vector A=B={1,...,1} gives outp=8.
- Async reset asserted mid-ACCUM between clock edges -> out_valid=0, outp=0, busy=0 immediately; the next full vector computes correctly.
